sao_lcu_feeder: RTL and testbench
=================================

// Module: sao_lcu_feeder
// PURPOSE
//  Transmit side of the SAO pixel-stream interface. Reads a 128x128 8-bit frame from a
//  16384x8 sync SRAM and drives din/in_en plus per-LCU lcu_x/lcu_y/lcu_size into the SAO
//  filter, LCU by LCU. Honours the filter's busy back-pressure. Sits between frame store and SAO.
// PARAMETERS
//  FRAME_W  128  frame width/height in pixels (power of 2)
//  ADDR_W   14   SRAM address width (log2(FRAME_W*FRAME_W))
//  DATA_W   8    pixel width
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       1-cycle pulse: begin streaming a frame (ignored unless IDLE)
//  lcu_size_cfg in   2       0:16, 1:32, 2:64, 3:treated as 16; sampled on accepted start
//  sram_cen     out  1       SRAM chip enable, active low
//  sram_a       out  ADDR_W  SRAM read address
//  sram_q       in   DATA_W  SRAM read data, valid 1 cycle after cen=0 edge
//  busy         in   1       from SAO: 1 = current din not accepted this cycle
//  in_en        out  1       din valid
//  din          out  DATA_W  pixel
//  lcu_x,lcu_y  out  3       LCU coordinates of current pixel
//  lcu_size     out  2       registered lcu_size_cfg
//  active       out  1       1 from accepted start until frame_done
//  frame_done   out  1       1-cycle pulse after final pixel transfers
// BEHAVIOUR
//  - Reset values: in_en=0, din=0, lcu_x=lcu_y=0, lcu_size=0, active=0, frame_done=0,
//    sram_cen=1, sram_a=0; FSM=IDLE; buffer empty. Reset mid-frame aborts with no further output.
//  - Transfer: pixel consumed on clock edge where in_en=1 && busy=0. While busy=1 with
//    in_en=1, din/lcu_x/lcu_y/lcu_size hold unchanged.
//  - FSM: IDLE --start--> FETCH (reset counters, latch size) -> STREAM -> (last pixel
//    transferred) DONE -> IDLE. DONE lasts 1 cycle, frame_done=1, active=0 in following cycle.
//  - Order: lcu_y outer, lcu_x inner, N=FRAME_W/W LCUs per axis (8/4/2); within an LCU,
//    rows py=0..W-1, columns px=0..W-1. sram_a = (lcu_y*W+py)*FRAME_W + lcu_x*W + px.
//  - Read pipeline: SRAM latency 1; 2-entry output skid buffer. Read issued (cen=0) only
//    when buffer occupancy + reads in flight < 2 after this cycle's transfer. Never drops or
//    duplicates a pixel under any busy pattern. Full throughput (1 pixel/cycle) when busy=0.
//  - First in_en=1 no earlier than 2 cycles after start. No reads issued past last pixel.
//  - lcu_x/lcu_y/lcu_size travel with the pixel in the buffer; advance only at first pixel
//    of next LCU. lcu_size_cfg changes while active are ignored.
//  - Counters: px,py 6-bit wrap at W-1; LCU index wraps at N-1; final pixel = all at max.
//  - start coincident with DONE is ignored; start must be re-pulsed in IDLE.
// CONFIGURATION
//  LCU_GAP_EN defined: after last pixel of each LCU transfers, in_en=0 for exactly 1 cycle
//   before next LCU's first pixel (consumer re-samples params on in_en). Reads continue;
//   buffer holds data. Frame takes 16384 + (N*N-1) cycles minimum.
//  LCU_GAP_EN undefined: LCUs back-to-back, no gap; 16384 cycles minimum with busy=0.
// TESTING
//  T1 size 0, busy=0, SRAM[a]=a[7:0]: 16384 transfers, pixel k of LCU(0,0) row1 = 128+px,
//     LCU(1,0) first din=16, frame_done pulses once, active low next cycle.
//  T2 size 2, random busy 50%: 4 LCUs, order (0,0),(1,0),(0,1),(1,1); scoreboard vs
//     computed address, zero drops/dups; din held stable every busy=1 cycle.
//  T3 size 1, busy=1 for 10 cycles at pixel 31 of row 0: din stays SRAM[31]; next accepted
//     din = SRAM[128] (row 1, px0); sram_cen never issues > 2 outstanding.
//  T4 reset asserted at pixel 5000: all outputs to reset values asynchronously; start
//     after release streams from SRAM[0] again.
//  T5 start pulsed while active and lcu_size_cfg toggled: no restart, size unchanged,
//     single frame_done.
//  T6 LCU_GAP_EN defined, size 0, busy=0: exactly one in_en=0 cycle between each LCU
//     (63 gaps), total 16447 cycles to frame_done.

Source files
------------

// File: rtl/sao_lcu_feeder.sv
// sao_lcu_feeder: streams a FRAME_W x FRAME_W frame from a 1-cycle-latency sync SRAM
// into the SAO filter, LCU by LCU, behind a 2-entry skid buffer that absorbs busy.
// Optional build macro: LCU_GAP_EN inserts one idle in_en cycle between LCUs.
module sao_lcu_feeder #(
  parameter int FRAME_W = 128,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        lcu_size_cfg,
  output logic              sram_cen,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_q,
  input  logic              busy,
  output logic              in_en,
  output logic [DATA_W-1:0] din,
  output logic [2:0]        lcu_x,
  output logic [2:0]        lcu_y,
  output logic [1:0]        lcu_size,
  output logic              active,
  output logic              frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_size;
  logic [5:0]        r_px, r_py;
  logic [2:0]        r_lx, r_ly;
  logic              r_issue_done;
  logic              r_vld_p1;
  logic [2:0]        r_x_p1, r_y_p1;
  logic              r_fl_p1;
  logic [DATA_W-1:0] r_d0, r_d1;
  logic [2:0]        r_x0, r_x1, r_y0, r_y1;
  logic              r_fl0, r_fl1;
  logic [1:0]        r_cnt;

  logic [5:0]        w_wmax;
  logic [2:0]        w_nmax;
  logic              w_px_max, w_py_max, w_lx_max, w_ly_max;
  logic              w_hold, w_xfer, w_issue, w_shift, w_ld0, w_ld1;
  logic [2:0]        w_occ;
  logic [1:0]        w_cnt_pop;

  // Largest pixel index inside an LCU; size code 3 falls back to 16x16.
  function automatic logic [5:0] wmax_f(input logic [1:0] s);
    case (s)
      2'd1:    return 6'd31;
      2'd2:    return 6'd63;
      default: return 6'd15;
    endcase
  endfunction

  // Largest LCU index along one frame axis.
  function automatic logic [2:0] nmax_f(input logic [1:0] s);
    case (s)
      2'd1:    return 3'((FRAME_W / 32) - 1);
      2'd2:    return 3'((FRAME_W / 64) - 1);
      default: return 3'((FRAME_W / 16) - 1);
    endcase
  endfunction

  // Raster address of pixel (px,py) inside LCU (lx,ly).
  function automatic logic [ADDR_W-1:0] addr_f(input logic [2:0] lx, input logic [2:0] ly,
                                               input logic [5:0] px, input logic [5:0] py,
                                               input logic [5:0] wm);
    int w;
    w = int'(wm) + 1;
    return ADDR_W'((int'(ly) * w + int'(py)) * FRAME_W + int'(lx) * w + int'(px));
  endfunction

  assign w_wmax   = wmax_f(r_size);
  assign w_nmax   = nmax_f(r_size);
  assign w_px_max = (r_px == w_wmax);
  assign w_py_max = (r_py == w_wmax);
  assign w_lx_max = (r_lx == w_nmax);
  assign w_ly_max = (r_ly == w_nmax);

`ifdef LCU_GAP_EN
  logic r_ll_p1, r_ll0, r_ll1, r_gap;
  assign w_hold = r_gap;
`else
  assign w_hold = 1'b0;
`endif

  // Head of the skid buffer is what the filter sees.
  assign in_en     = (r_cnt != 2'd0) && !w_hold;
  assign w_xfer    = in_en && !busy;
  // Occupancy after this edge, counting the read that lands on it.
  assign w_occ     = {1'b0, r_cnt} - {2'b00, w_xfer} + {2'b00, r_vld_p1};
  assign w_issue   = ((r_state == S_FETCH) || (r_state == S_STREAM)) && !r_issue_done &&
                     (w_occ < 3'd2);
  assign sram_cen  = !w_issue;
  assign sram_a    = addr_f(r_lx, r_ly, r_px, r_py, w_wmax);
  assign w_cnt_pop = r_cnt - {1'b0, w_xfer};
  assign w_shift   = w_xfer && (r_cnt == 2'd2);
  assign w_ld0     = w_shift || (r_vld_p1 && (w_cnt_pop == 2'd0));
  assign w_ld1     = r_vld_p1 && (w_cnt_pop == 2'd1);
  assign din       = r_d0;
  assign lcu_x     = r_x0;
  assign lcu_y     = r_y0;
  assign lcu_size  = r_size;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: frame ends when the pixel tagged frame-last is accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_STREAM;
      S_STREAM: if (w_xfer && r_fl0) w_state_nxt = S_DONE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: active stays high through the done pulse.
  always_comb begin
    active     = (r_state != S_IDLE);
    frame_done = (r_state == S_DONE);
  end

  // ---- stage p0: address counters, read issue and buffer occupancy ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_size       <= 2'd0;
      r_px         <= 6'd0;
      r_py         <= 6'd0;
      r_lx         <= 3'd0;
      r_ly         <= 3'd0;
      r_issue_done <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_cnt        <= 2'd0;
    end else begin
      r_vld_p1 <= w_issue;
      r_cnt    <= w_cnt_pop + {1'b0, r_vld_p1};
      if ((r_state == S_IDLE) && start) begin
        r_size       <= lcu_size_cfg;
        r_px         <= 6'd0;
        r_py         <= 6'd0;
        r_lx         <= 3'd0;
        r_ly         <= 3'd0;
        r_issue_done <= 1'b0;
      end else if (w_issue) begin
        if (!w_px_max) r_px <= r_px + 6'd1;
        else begin
          r_px <= 6'd0;
          if (!w_py_max) r_py <= r_py + 6'd1;
          else begin
            r_py <= 6'd0;
            if (!w_lx_max) r_lx <= r_lx + 3'd1;
            else begin
              r_lx <= 3'd0;
              if (!w_ly_max) r_ly <= r_ly + 3'd1;
              else begin
                r_ly         <= 3'd0;
                r_issue_done <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // ---- stage p1: read in flight, LCU tags travel alongside ----
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_x_p1  <= r_lx;
      r_y_p1  <= r_ly;
      r_fl_p1 <= w_px_max && w_py_max && w_lx_max && w_ly_max;
    end
  end

  // ---- stage p2: buffer head, loaded from entry 1 on shift or from SRAM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d0  <= '0;
      r_x0  <= 3'd0;
      r_y0  <= 3'd0;
      r_fl0 <= 1'b0;
    end else if (w_ld0) begin
      r_d0  <= w_shift ? r_d1  : sram_q;
      r_x0  <= w_shift ? r_x1  : r_x_p1;
      r_y0  <= w_shift ? r_y1  : r_y_p1;
      r_fl0 <= w_shift ? r_fl1 : r_fl_p1;
    end
  end

  // Buffer entry 1 catches the arriving pixel while the head is stalled.
  always_ff @(posedge clk) begin
    if (w_ld1) begin
      r_d1  <= sram_q;
      r_x1  <= r_x_p1;
      r_y1  <= r_y_p1;
      r_fl1 <= r_fl_p1;
    end
  end

`ifdef LCU_GAP_EN
  // LCU-last tag follows the read through the pipeline.
  always_ff @(posedge clk) begin
    if (w_issue) r_ll_p1 <= w_px_max && w_py_max;
    if (w_ld0)   r_ll0   <= w_shift ? r_ll1 : r_ll_p1;
    if (w_ld1)   r_ll1   <= r_ll_p1;
  end

  // One idle cycle after each LCU except the last so the filter re-samples its parameters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_gap <= 1'b0;
    else       r_gap <= w_xfer && r_ll0 && !r_fl0;
  end
`endif

endmodule

// File: tb/tb_sao_lcu_feeder.sv
// Scoreboard bench for sao_lcu_feeder: stimulus pushes expected pixels, a monitor pops them.
module tb_sao_lcu_feeder;

`ifdef LCU_GAP_EN
  localparam int GAPS = 63;
`else
  localparam int GAPS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, busy;
  logic [1:0] lcu_size_cfg;
  logic       sram_cen, in_en, active, frame_done;
  logic [13:0] sram_a;
  logic [7:0] sram_q = 8'd0;
  logic [7:0] din;
  logic [2:0] lcu_x, lcu_y;
  logic [1:0] lcu_size;

  typedef struct packed {logic [7:0] d; logic [2:0] x; logic [2:0] y; logic [1:0] s;} exp_t;
  exp_t exp_q[$];

  logic [7:0] mem    [16384];
  logic [7:0] xf_din [16384];
  logic [2:0] xf_x   [16384];
  logic [2:0] xf_y   [16384];

  int n_vec = 0, n_fail = 0;
  int n_xf = 0, n_iss = 0, n_gap = 0, n_done = 0, max_out = 0, done_cyc = 0, cyc = 0;
  int base_xf = 0, base_gap = 0, base_done = 0, base_iss = 0, st_cyc = 0;
  int bmode = 0, hcnt = 0;
  logic hold_v = 1'b0, prev_done = 1'b0;
  logic [13:0] hold_v_dat;

  sao_lcu_feeder dut (
    .clk(clk), .reset(reset), .start(start), .lcu_size_cfg(lcu_size_cfg),
    .sram_cen(sram_cen), .sram_a(sram_a), .sram_q(sram_q), .busy(busy),
    .in_en(in_en), .din(din), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
    .active(active), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM, one cycle read latency.
  always @(posedge clk) if (!sram_cen) sram_q <= mem[sram_a];

  function automatic logic [7:0] pix(input int a);
    logic [13:0] v;
    v = a[13:0];
    return v[7:0] ^ {v[13:8], 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic push_frame(input logic [1:0] sz);
    int w, n, a;
    exp_t e;
    w = (sz == 2'd1) ? 32 : (sz == 2'd2) ? 64 : 16;
    n = 128 / w;
    for (int ly = 0; ly < n; ly++)
      for (int lx = 0; lx < n; lx++)
        for (int py = 0; py < w; py++)
          for (int px = 0; px < w; px++) begin
            a   = (ly * w + py) * 128 + lx * w + px;
            e.d = pix(a);
            e.x = 3'(lx);
            e.y = 3'(ly);
            e.s = sz;
            exp_q.push_back(e);
          end
  endtask

  task automatic start_frame(input logic [1:0] sz);
    base_xf      = n_xf;
    base_gap     = n_gap;
    base_done    = n_done;
    base_iss     = n_iss;
    lcu_size_cfg = sz;
    push_frame(sz);
    start = 1'b1;
    @(posedge clk); #1;
    st_cyc = cyc;
    start  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int b;
    b = 0;
    while (n_done == base_done && b < budget) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (n_done == base_done) chk({nm, "_done_timeout"}, n_done, base_done + 1);
  endtask

  task automatic wait_xf(input string nm, input int cnt, input int budget);
    int b;
    b = 0;
    while ((n_xf - base_xf) < cnt && b < budget) begin
      @(posedge clk);
      b++;
    end
    if ((n_xf - base_xf) < cnt) chk({nm, "_xfer_timeout"}, n_xf - base_xf, cnt);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_in_en"},      in_en,      0);
    chk({nm, "_din"},        din,        0);
    chk({nm, "_lcu_x"},      lcu_x,      0);
    chk({nm, "_lcu_y"},      lcu_y,      0);
    chk({nm, "_lcu_size"},   lcu_size,   0);
    chk({nm, "_active"},     active,     0);
    chk({nm, "_frame_done"}, frame_done, 0);
    chk({nm, "_sram_cen"},   sram_cen,   1);
    chk({nm, "_sram_a"},     sram_a,     0);
  endtask

  // Monitor: pops the scoreboard on every accepted pixel, checks hold under busy.
  always @(negedge clk) begin
    int idx;
    exp_t e;
    if (reset) begin
      hold_v    = 1'b0;
      prev_done = 1'b0;
      n_iss     = n_xf;
    end else begin
      if (prev_done) chk("active_after_done", active, 0);
      prev_done = frame_done;
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (!sram_cen) n_iss++;
      if (hold_v && in_en) chk("hold_under_busy", {din, lcu_x, lcu_y}, hold_v_dat);
      hold_v     = in_en && busy;
      hold_v_dat = {din, lcu_x, lcu_y};
      if (in_en && !busy) begin
        idx = n_xf - base_xf;
        if (exp_q.size() == 0) chk($sformatf("extra_pixel[%0d]", idx), exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("pix[%0d]", idx), {din, lcu_x, lcu_y, lcu_size}, e);
        end
        if (idx >= 0 && idx < 16384) begin
          xf_din[idx] = din;
          xf_x[idx]   = lcu_x;
          xf_y[idx]   = lcu_y;
        end
        n_xf++;
      end else if (!in_en && (n_xf > base_xf) && exp_q.size() > 0) begin
        n_gap++;
      end
      if (n_iss - n_xf > max_out) max_out = n_iss - n_xf;
    end
  end

  // Back-pressure driver: 0 none, 1 random 50%, 2 ten-cycle stall at pixel 31.
  initial begin
    busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (bmode)
        1:       busy = ($urandom_range(0, 1) == 1);
        2: begin
          busy = ((n_xf - base_xf) == 31) && (hcnt < 10);
          if (busy) hcnt++;
        end
        default: busy = 1'b0;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    for (int a = 0; a < 16384; a++) mem[a] = pix(a);
    reset = 1'b1; start = 1'b0; lcu_size_cfg = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst0");
    reset = 1'b0;
    @(posedge clk); #1;

    // T1: 16x16 LCUs, no back-pressure.
    start_frame(2'd0);
    repeat (200) @(posedge clk);
    #1;
    chk("t1_active_mid", active, 1);
    wait_done("t1", 20000);
    d = done_cyc - st_cyc;
    chk("t1_cycles_in_range", (d >= 16384 + GAPS) && (d <= 16392 + GAPS), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_done_once",   n_done - base_done, 1);
    chk("t1_xfers",       n_xf - base_xf,     16384);
    chk("t1_reads",       n_iss - base_iss,   16384);
    chk("t1_queue_empty", exp_q.size(),       0);
    chk("t1_gaps",        n_gap - base_gap,   GAPS);
    chk("t1_row1_px0",    xf_din[16],         128);
    chk("t1_row1_px5",    xf_din[21],         133);
    chk("t1_lcu10_din",   xf_din[256],        16);
    chk("t1_lcu10_x",     xf_x[256],          1);
    chk("t1_lcu10_y",     xf_y[256],          0);
    chk("t1_lcu01_din",   xf_din[2048],       32);
    chk("t1_lcu01_y",     xf_y[2048],         1);
    chk("t1_idle_in_en",  in_en,              0);

    // T2: 64x64 LCUs under random busy.
    bmode = 1;
    start_frame(2'd2);
    wait_done("t2", 60000);
    bmode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_xfers",       n_xf - base_xf, 16384);
    chk("t2_queue_empty", exp_q.size(),   0);
    chk("t2_lcu10_din",   xf_din[4096],   64);
    chk("t2_lcu10_xy",    {xf_x[4096],  xf_y[4096]},  {3'd1, 3'd0});
    chk("t2_lcu01_din",   xf_din[8192],   128);
    chk("t2_lcu01_xy",    {xf_x[8192],  xf_y[8192]},  {3'd0, 3'd1});
    chk("t2_lcu11_din",   xf_din[12288],  192);
    chk("t2_lcu11_xy",    {xf_x[12288], xf_y[12288]}, {3'd1, 3'd1});

    // T3: 32x32 LCUs, ten-cycle stall on the last pixel of row 0.
    bmode = 2;
    start_frame(2'd1);
    wait_done("t3", 20000);
    bmode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_busy_cycles",  hcnt,         10);
    chk("t3_px31",         xf_din[31],   31);
    chk("t3_row1_px0",     xf_din[32],   128);
    chk("t3_lcu10_din",    xf_din[1024], 32);
    chk("t3_xfers",        n_xf - base_xf, 16384);
    chk("max_outstanding_le2", max_out <= 2, 1);

    // T4: asynchronous reset mid-frame, then restart from address 0.
    start_frame(2'd0);
    wait_xf("t4", 5000, 7000);
    #2;
    reset = 1'b1;
    #1;
    chk_reset("t4_async");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset("t4_idle");
    start_frame(2'd0);
    wait_xf("t4b", 20, 200);
    #1;
    chk("t4_first_din", xf_din[0],  0);
    chk("t4_row1_din",  xf_din[16], 128);
    #2;
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // T5: start and size changes while active are ignored.
    start_frame(2'd2);
    repeat (300) @(posedge clk);
    #1;
    lcu_size_cfg = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lcu_size_cfg = 2'd1;
    repeat (50) @(posedge clk);
    #1;
    lcu_size_cfg = 2'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_size_mid", lcu_size, 2);
    wait_done("t5", 20000);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_done_once",   n_done - base_done, 1);
    chk("t5_xfers",       n_xf - base_xf,     16384);
    chk("t5_queue_empty", exp_q.size(),       0);
    chk("t5_size_end",    lcu_size,           2);
    chk("t5_active_end",  active,             0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
